// File: rtl/delay_tap_scheduler.sv
// delay_tap_scheduler
//
// Turns one shared dual-port delay RAM (registered read) into a multi-tap
// delay line. Each sample_tick writes one sample, then issues one read per
// tap at (write address - tap length). When every tap's data is back, all
// tap outputs are presented together with a single q_valid pulse.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   sample_tick     one-cycle pulse, new sample present on d
//   d               input sample (taken only when idle)
//   tap_len         per-tap delay in samples, tap i at [i*ADDR_W +: ADDR_W]
//   q               tap outputs, tap i at [i*DATA_W +: DATA_W]
//   q_valid         one-cycle pulse when q takes new values
//   busy            high while a sample is being processed
//   overrun         sticky, set when a tick arrives while busy
//   mem_*           write/read ports of the external delay RAM
//   mem_q           RAM read data, RD_LATENCY cycles after the read request

module delay_tap_scheduler #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int NUM_TAPS   = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic [DATA_W-1:0]          d,
  input  logic [NUM_TAPS*ADDR_W-1:0] tap_len,
  output logic [NUM_TAPS*DATA_W-1:0] q,
  output logic                       q_valid,
  output logic                       busy,
  output logic                       overrun,
  output logic [ADDR_W-1:0]          mem_wraddress,
  output logic [DATA_W-1:0]          mem_data,
  output logic                       mem_wren,
  output logic [ADDR_W-1:0]          mem_rdaddress,
  output logic                       mem_rden,
  input  logic [DATA_W-1:0]          mem_q
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int DRN_W = $clog2(RD_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_TAP   = IDX_W'(NUM_TAPS - 1);
  localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0]          wr_ptr;
  logic [ADDR_W-1:0]          wp;
  logic [DATA_W-1:0]          d_lat;
  logic [ADDR_W-1:0]          len_lat   [NUM_TAPS];
  logic [IDX_W-1:0]           rd_idx;
  logic [DRN_W-1:0]           drain_cnt;
  logic [DATA_W-1:0]          shadow    [NUM_TAPS];
  logic [NUM_TAPS*DATA_W-1:0] shadow_flat;
  logic [NUM_TAPS*DATA_W-1:0] q_reg;
  logic [ADDR_W-1:0]          eff_len;

  // Read-tracking pipeline: one stage per cycle of RAM latency, carrying
  // which tap the in-flight read belongs to.
  logic [RD_LATENCY-1:0]      pipe_vld;
  logic [IDX_W-1:0]           pipe_idx  [RD_LATENCY];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and RAM/handshake outputs
  always_comb begin
    state_next    = state;
    mem_wren      = 1'b0;
    mem_wraddress = '0;
    mem_data      = '0;
    mem_rden      = 1'b0;
    mem_rdaddress = '0;
    q_valid       = 1'b0;
    busy          = (state != S_IDLE);
    // A zero length would read the slot just written; treat it as one.
    eff_len       = len_lat[rd_idx];
    if (eff_len == '0) begin
      eff_len = ADDR_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (sample_tick) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_wren      = 1'b1;
        mem_wraddress = wr_ptr;
        mem_data      = d_lat;
        state_next    = S_READ;
      end
      S_READ: begin
        mem_rden      = 1'b1;
        mem_rdaddress = wp - eff_len;
        if (rd_idx == LAST_TAP) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == LAST_DRAIN) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        q_valid    = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Flatten shadows; q shows them directly during DONE so the data lines up
  // with the q_valid pulse, and holds the registered copy afterwards.
  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      shadow_flat[i*DATA_W +: DATA_W] = shadow[i];
    end
    q = (state == S_DONE) ? shadow_flat : q_reg;
  end

  // Datapath: latches, pointers, counters, read tracking, result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      wp        <= '0;
      d_lat     <= '0;
      rd_idx    <= '0;
      drain_cnt <= '0;
      q_reg     <= '0;
      overrun   <= 1'b0;
      pipe_vld  <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        len_lat[i] <= '0;
        shadow[i]  <= '0;
      end
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_idx[s] <= '0;
      end
    end else begin
      if (sample_tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            d_lat <= d;
            for (int i = 0; i < NUM_TAPS; i++) begin
              len_lat[i] <= tap_len[i*ADDR_W +: ADDR_W];
            end
          end
        end
        S_WRITE: begin
          wp     <= wr_ptr;
          wr_ptr <= wr_ptr + 1'b1;
          rd_idx <= '0;
        end
        S_READ: begin
          rd_idx    <= rd_idx + 1'b1;
          drain_cnt <= '0;
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
        end
        S_DONE: begin
          q_reg <= shadow_flat;
        end
        default: begin
        end
      endcase

      pipe_vld[0] <= mem_rden;
      pipe_idx[0] <= rd_idx;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_idx[s] <= pipe_idx[s-1];
      end

      // The last stage lines up with the cycle mem_q carries that read.
      if (pipe_vld[RD_LATENCY-1]) begin
        shadow[pipe_idx[RD_LATENCY-1]] <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// tb_delay_tap_scheduler
//
// Directed bench for delay_tap_scheduler with a behavioural 16x1024 RAM
// (two-cycle registered read). Covers latency, multi-tap delay, zero-length
// clamp, overrun, reset mid-sequence and address wrap-around.

module tb_delay_tap_scheduler;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 10;
  localparam int NUM_TAPS   = 4;
  localparam int RD_LATENCY = 2;

  logic                       clk;
  logic                       reset;
  logic                       sample_tick;
  logic [DATA_W-1:0]          d;
  logic [NUM_TAPS*ADDR_W-1:0] tap_len;
  logic [NUM_TAPS*DATA_W-1:0] q;
  logic                       q_valid;
  logic                       busy;
  logic                       overrun;
  logic [ADDR_W-1:0]          mem_wraddress;
  logic [DATA_W-1:0]          mem_data;
  logic                       mem_wren;
  logic [ADDR_W-1:0]          mem_rdaddress;
  logic                       mem_rden;
  logic [DATA_W-1:0]          mem_q = '0;

  delay_tap_scheduler #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TAPS(NUM_TAPS), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .d(d), .tap_len(tap_len),
    .q(q), .q_valid(q_valid), .busy(busy), .overrun(overrun),
    .mem_wraddress(mem_wraddress), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_rdaddress(mem_rdaddress), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, two cycles from request to mem_q
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1] = '{default: '0};
  logic [DATA_W-1:0] rd_stage = '0;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_wraddress] <= mem_data;
    if (mem_rden) rd_stage <= ram[mem_rdaddress];
    mem_q <= rd_stage;
  end

  // Cycle counter and mid-cycle event log
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int               wr_count = 0;
  int               qv_count = 0;
  int               rd_in_seq = 0;
  int               first_rd_cyc = 0;
  int               last_qv_cyc = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [DATA_W-1:0] last_wr_data = '0;
  logic [ADDR_W-1:0] first_rd_addr = '0;

  always @(negedge clk) begin
    if (mem_wren) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_wraddress;
      last_wr_data <= mem_data;
      rd_in_seq    <= 0;
    end
    if (mem_rden) begin
      if (rd_in_seq == 0) begin
        first_rd_cyc  <= cyc;
        first_rd_addr <= mem_rdaddress;
      end
      rd_in_seq <= rd_in_seq + 1;
    end
    if (q_valid) begin
      qv_count    <= qv_count + 1;
      last_qv_cyc <= cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset       = 1'b1;
    sample_tick = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One tick, then wait (bounded) for q_valid and leave the bench one cycle
  // after DONE so the next tick lands in IDLE. tap_len and d are scrambled
  // after the tick to show they were latched.
  task automatic applyStimulus(input logic [DATA_W-1:0] dv,
                               input logic [NUM_TAPS*ADDR_W-1:0] tl,
                               output int t0);
    int n;
    d           = dv;
    tap_len     = tl;
    sample_tick = 1'b1;
    t0          = cyc;
    step();
    sample_tick = 1'b0;
    d           = ~dv;
    tap_len     = ~tl;
    n = 0;
    while (!q_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput("qv_seen", 64'(q_valid), 64'd1);
    step();
  endtask

  typedef struct {
    logic [DATA_W-1:0]          d;
    logic [NUM_TAPS*ADDR_W-1:0] tl;
    logic [NUM_TAPS*DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0]          exp_wr;
    logic [ADDR_W-1:0]          exp_rd0;
  } vec_t;

  vec_t vecs [12];

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    logic [NUM_TAPS*ADDR_W-1:0] tl_a;
    logic [NUM_TAPS*ADDR_W-1:0] tl_w;
    int t0;
    int qv_before;
    int wr_before;

    tl_a = {10'd4, 10'd3, 10'd2, 10'd1};
    vecs[0]  = '{16'd0,  tl_a, {16'd0, 16'd0, 16'd0, 16'd0}, 10'd0,  10'd1023};
    vecs[1]  = '{16'd1,  tl_a, {16'd0, 16'd0, 16'd0, 16'd0}, 10'd1,  10'd0};
    vecs[2]  = '{16'd2,  tl_a, {16'd0, 16'd0, 16'd0, 16'd1}, 10'd2,  10'd1};
    vecs[3]  = '{16'd3,  tl_a, {16'd0, 16'd0, 16'd1, 16'd2}, 10'd3,  10'd2};
    vecs[4]  = '{16'd4,  tl_a, {16'd0, 16'd1, 16'd2, 16'd3}, 10'd4,  10'd3};
    vecs[5]  = '{16'd5,  tl_a, {16'd1, 16'd2, 16'd3, 16'd4}, 10'd5,  10'd4};
    vecs[6]  = '{16'd6,  tl_a, {16'd2, 16'd3, 16'd4, 16'd5}, 10'd6,  10'd5};
    vecs[7]  = '{16'd7,  tl_a, {16'd3, 16'd4, 16'd5, 16'd6}, 10'd7,  10'd6};
    vecs[8]  = '{16'd8,  tl_a, {16'd4, 16'd5, 16'd6, 16'd7}, 10'd8,  10'd7};
    vecs[9]  = '{16'd9,  tl_a, {16'd5, 16'd6, 16'd7, 16'd8}, 10'd9,  10'd8};
    // tap0 length 0 behaves as length 1
    vecs[10] = '{16'd10, {10'd10, 10'd9, 10'd5, 10'd0},
                 {16'd0, 16'd1, 16'd5, 16'd9}, 10'd10, 10'd9};
    vecs[11] = '{16'd11, {10'd6, 10'd11, 10'd1023, 10'd1},
                 {16'd5, 16'd0, 16'd0, 16'd10}, 10'd11, 10'd10};

    reset       = 1'b1;
    sample_tick = 1'b0;
    d           = '0;
    tap_len     = '0;

    // Reset state and single-tick latency profile
    doReset();
    checkOutput("rst_q",       64'(q),             64'd0);
    checkOutput("rst_qvalid",  64'(q_valid),       64'd0);
    checkOutput("rst_busy",    64'(busy),          64'd0);
    checkOutput("rst_overrun", 64'(overrun),       64'd0);
    checkOutput("rst_wren",    64'(mem_wren),      64'd0);
    checkOutput("rst_rden",    64'(mem_rden),      64'd0);
    checkOutput("rst_wraddr",  64'(mem_wraddress), 64'd0);
    checkOutput("rst_rdaddr",  64'(mem_rdaddress), 64'd0);
    checkOutput("rst_data",    64'(mem_data),      64'd0);

    d           = 16'h1234;
    tap_len     = tl_a;
    sample_tick = 1'b1;
    checkOutput("lat_busy_c0", 64'(busy), 64'd0);
    step();
    sample_tick = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      checkOutput($sformatf("lat_wren_c%0d", c), 64'(mem_wren), 64'(c == 1));
      checkOutput($sformatf("lat_rden_c%0d", c), 64'(mem_rden), 64'(c >= 2 && c <= 5));
      checkOutput($sformatf("lat_qv_c%0d", c),   64'(q_valid),  64'(c == 8));
      checkOutput($sformatf("lat_busy_c%0d", c), 64'(busy),     64'(c >= 1 && c <= 8));
      if (c == 1) begin
        checkOutput("lat_wraddr", 64'(mem_wraddress), 64'd0);
        checkOutput("lat_wdata",  64'(mem_data),      64'h1234);
      end
      if (c == 8) checkOutput("lat_q", 64'(q), 64'd0);
      if (c < 10) step();
    end

    // Table-driven multi-tap delay and clamp rows
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].d, vecs[i].tl, t0);
      checkOutput($sformatf("vec%0d_q", i),     64'(q),             64'(vecs[i].exp_q));
      checkOutput($sformatf("vec%0d_wr", i),    64'(last_wr_addr),  64'(vecs[i].exp_wr));
      checkOutput($sformatf("vec%0d_wd", i),    64'(last_wr_data),  64'(vecs[i].d));
      checkOutput($sformatf("vec%0d_rd0", i),   64'(first_rd_addr), 64'(vecs[i].exp_rd0));
      checkOutput($sformatf("vec%0d_nrd", i),   64'(rd_in_seq),     64'd4);
      checkOutput($sformatf("vec%0d_rdlat", i), 64'(first_rd_cyc - t0), 64'd2);
      checkOutput($sformatf("vec%0d_qvlat", i), 64'(last_qv_cyc - t0),  64'd8);
    end

    // Reset during READ aborts the sequence
    qv_before   = qv_count;
    d           = 16'h0077;
    tap_len     = tl_a;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busy),     64'd0);
    checkOutput("abort_q",    64'(q),        64'd0);
    checkOutput("abort_qv",   64'(q_valid),  64'd0);
    checkOutput("abort_rden", 64'(mem_rden), 64'd0);
    for (int k = 0; k < 8; k++) step();
    checkOutput("abort_no_qv", 64'(qv_count), 64'(qv_before));
    applyStimulus(16'h0055, tl_a, t0);
    checkOutput("abort_fresh_wr", 64'(last_wr_addr), 64'd0);
    checkOutput("abort_fresh_wd", 64'(last_wr_data), 64'h0055);

    // Tick while busy: ignored, overrun sticks
    checkOutput("ovr_clear", 64'(overrun), 64'd0);
    wr_before   = wr_count;
    qv_before   = qv_count;
    d           = 16'h00AA;
    tap_len     = tl_a;
    sample_tick = 1'b1;
    t0          = cyc;
    step();
    sample_tick = 1'b0;
    step();
    step();
    d           = 16'h00BB;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checkOutput("ovr_set", 64'(overrun), 64'd1);
    for (int k = 0; k < 20 && !q_valid; k++) step();
    checkOutput("ovr_qv_seen", 64'(q_valid), 64'd1);
    step();
    checkOutput("ovr_qvlat",  64'(last_qv_cyc - t0),     64'd8);
    checkOutput("ovr_qvcnt",  64'(qv_count - qv_before), 64'd1);
    checkOutput("ovr_wrcnt",  64'(wr_count - wr_before), 64'd1);
    checkOutput("ovr_wraddr", 64'(last_wr_addr),         64'd1);
    checkOutput("ovr_wdata",  64'(last_wr_data),         64'h00AA);
    checkOutput("ovr_q",      64'(q), 64'({16'd0, 16'd0, 16'd0, 16'h0055}));
    applyStimulus(16'h00CC, tl_a, t0);
    checkOutput("ovr_next_wr", 64'(last_wr_addr), 64'd2);
    checkOutput("ovr_next_q",  64'(q), 64'({16'd0, 16'd0, 16'h0055, 16'h00AA}));
    checkOutput("ovr_sticky",  64'(overrun), 64'd1);

    // Address wrap-around with the longest delay
    doReset();
    checkOutput("wrap_ovr_rst", 64'(overrun), 64'd0);
    tl_w = {10'd3, 10'd2, 10'd1, 10'd1023};
    for (int k = 0; k < 1029; k++) begin
      applyStimulus(16'(k), tl_w, t0);
    end
    applyStimulus(16'd1029, tl_w, t0);
    checkOutput("wrap_wraddr", 64'(last_wr_addr),  64'd5);
    checkOutput("wrap_rd0",    64'(first_rd_addr), 64'd6);
    checkOutput("wrap_q",      64'(q), 64'({16'd1026, 16'd1027, 16'd1028, 16'd6}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_tap_scheduler.md
Name: delay_tap_scheduler

Overview:
Sequences one shared 16-bit x 1024 dual-port delay RAM (registered read) so it serves as a multi-tap delay line. On each sample_tick it writes one input sample, then issues one read per tap, each at a configurable delay length. When all tap results are back, it presents them together. It sits between the sample-rate audio datapath and the delay memory, replacing fixed pointer-offset delay addressing.

Parameters:
DATA_W, 16, sample width
ADDR_W, 10, RAM address width; depth = 2^ADDR_W
NUM_TAPS, 4, number of delay taps served per sample
RD_LATENCY, 2, cycles from mem_rden/mem_rdaddress to valid mem_q

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle pulse: new sample on d
d  in  DATA_W  input sample, sampled when sample_tick=1 in IDLE
tap_len  in  NUM_TAPS*ADDR_W  per-tap delay in samples; tap i at [i*ADDR_W +: ADDR_W]
q  out  NUM_TAPS*DATA_W  tap outputs, same packing as tap_len
q_valid  out  1  one-cycle pulse when q updates
busy  out  1  high whenever FSM not in IDLE
overrun  out  1  sticky: sample_tick arrived while busy
mem_wraddress  out  ADDR_W  RAM write address
mem_data  out  DATA_W  RAM write data
mem_wren  out  1  RAM write enable
mem_rdaddress  out  ADDR_W  RAM read address
mem_rden  out  1  RAM read enable
mem_q  in  DATA_W  RAM read data

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state IDLE; wr_ptr=0; q=0; q_valid=0; busy=0; overrun=0; mem_wren=0; mem_rden=0; addresses and data 0. RAM contents are not cleared.
- FSM states: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: on sample_tick, latch d and all tap_len values; go to WRITE. Later tap_len changes have no effect until the next tick.
- WRITE (1 cycle): mem_wren=1, mem_wraddress=wr_ptr, mem_data=latched d. The written address is held as wp, and wr_ptr advances by 1, wrapping mod 2^ADDR_W.
- READ (NUM_TAPS cycles, tap 0 first): mem_rden=1, mem_rdaddress=(wp - L_i) mod 2^ADDR_W.
  - L_i is the latched tap_len_i, with 0 clamped to 1.
  - L=1 returns the previous sample; maximum delay is 2^ADDR_W-1.
- DRAIN: RD_LATENCY cycles with mem_rden=0. Read data for the read issued in cycle c is captured from mem_q at the end of cycle c+RD_LATENCY into a shadow register for that tap.
- DONE (1 cycle): copy all shadows to q together and pulse q_valid=1. q holds its value between updates.
- Timing: tick sampled in cycle T gives mem_wren in cycle T+1, reads in T+2..T+1+NUM_TAPS, and q_valid in T+NUM_TAPS+RD_LATENCY+2 (T+8 with defaults). busy is high from T+1 through the q_valid cycle.
- Minimum tick spacing is NUM_TAPS+RD_LATENCY+3 cycles.
- sample_tick while busy: ignored (no write, wr_ptr unchanged, current sequence unaffected); overrun set to 1 until reset.
- Reads never target the address being written in the same cycle, because write and read cycles are disjoint.
- Reset mid-sequence: abort immediately to the reset state. No q_valid; q=0.
- Uninitialised RAM: a tap reads unwritten data until the line has filled for its length. This is not an error.

Test Plan:
1. Latency: reset, tick at cycle 10 with d=0x1234 -> mem_wren=1 @11 addr 0 data 0x1234; mem_rden=1 @12..15; q_valid single pulse @18; busy high 11..18.
2. Basic delay: tap_len={1,2,3,4}, 10 ticks (spacing 12) with d=k for tick k=0..9 -> after tick 9: q tap0=8, tap1=7, tap2=6, tap3=5.
3. Wrap-around: tap_len0=1023, 1030 ticks with d=k -> after tick 1029: mem_wraddress=5 (1029 mod 1024), tap0 rdaddress=6, q tap0=6.
4. Clamp: tap_len0=0 -> same result as tap_len0=1 (previous sample); rdaddress = wp-1.
5. Overrun: second tick 3 cycles after the first -> no second write, wr_ptr increments once, overrun=1 and stays 1; first q_valid timing unchanged.
6. Reset mid-READ: assert reset at T+3 -> next cycle busy=0, q=0, no q_valid; a fresh tick then writes address 0.
